eth_mii_rx_framer: RTL and testbench

ETH_MII_RX_FRAMER -- requirements
Module: eth_mii_rx_framer

---
 rtl/eth_rx_pkg.sv | 25 ++
 rtl/eth_crc32_nibble.sv | 29 ++
 rtl/eth_mii_rx_framer.sv | 150 +++++++++++++++
 tb/tb_eth_mii_rx_framer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the MII receive framer and its CRC-32 checker.
package eth_rx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PREAMBLE,
      DATA,
      DROP
   } rx_state_t;

   localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
   localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
   localparam logic [31:0] CRC_POLY        = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_INIT        = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE     = 32'hC704_DD7B;
   localparam int          LEN_W           = 11;

   // Ethernet shifts LSB first, so the polynomial and residue are used bit-reversed.
   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

endpackage

// File: rtl/eth_crc32_nibble.sv
// Reflected CRC-32 register advanced one MII nibble per enabled clock.
// Built only when ETH_RX_CRC_EN is defined.
module eth_crc32_nibble
   import eth_rx_pkg::*;
(
   input  logic        eth_rx_clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        enable,
   input  logic [3:0]  nibble,
   output logic [31:0] crc
);

   localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [3:0] n);
      logic [31:0] r;
      // NOTE: blocking '=' is right here: r is a function-local temporary, not a flop.
      r = c ^ {28'd0, n};
      for (int i = 0; i < 4; i++) r = r[0] ? ((r >> 1) ^ POLY_REFL) : (r >> 1);
      return r;
   endfunction

   always_ff @(posedge eth_rx_clk) begin
      if (rst || clear) crc <= CRC_INIT;
      else if (enable)  crc <= crc_step(crc, nibble);
   end

endmodule

// File: rtl/eth_mii_rx_framer.sv
// MII receive framer: preamble/SFD detection, nibble-to-byte assembly with one-byte
// holdback so the last byte carries m_eof. Define ETH_RX_CRC_EN to add FCS checking.
module eth_mii_rx_framer
   import eth_rx_pkg::*;
#(
   parameter int MIN_PREAMBLE = 7,
   parameter int MAX_LEN      = 1522
)(
   input  logic             eth_rx_clk,
   input  logic             rst,
   input  logic             eth_rx_dv,
   input  logic [3:0]       eth_rxd,
   output logic [7:0]       m_data,
   output logic             m_valid,
   output logic             m_sof,
   output logic             m_eof,
   output logic             m_err,
   output logic [LEN_W-1:0] frame_len
);

   rx_state_t        state;
   logic [3:0]       pre_cnt;
   logic [3:0]       nib_lo;
   logic             have_nib;
   logic             rx_armed;
   logic [7:0]       hold_byte;
   logic [LEN_W-1:0] byte_cnt;
   logic             crc_bad;

`ifdef ETH_RX_CRC_EN
   logic        crc_clear;
   logic        crc_en;
   logic [31:0] crc_val;

   assign crc_clear = (state == PREAMBLE) && eth_rx_dv && (eth_rxd == SFD_NIBBLE);
   assign crc_en    = (state == DATA) && eth_rx_dv;

   eth_crc32_nibble u_crc (
      .eth_rx_clk (eth_rx_clk),
      .rst        (rst),
      .clear      (crc_clear),
      .enable     (crc_en),
      .nibble     (eth_rxd),
      .crc        (crc_val)
   );

   assign crc_bad = (crc_val != reflect32(CRC_RESIDUE));
`else
   assign crc_bad = 1'b0;
`endif

   // byte_cnt counts completed bytes; the held byte is always byte number byte_cnt.
   always_ff @(posedge eth_rx_clk) begin
      if (rst) begin
         state     <= IDLE;
         pre_cnt   <= '0;
         nib_lo    <= '0;
         have_nib  <= 1'b0;
         rx_armed  <= 1'b0;
         hold_byte <= '0;
         byte_cnt  <= '0;
         m_data    <= '0;
         m_valid   <= 1'b0;
         m_sof     <= 1'b0;
         m_eof     <= 1'b0;
         m_err     <= 1'b0;
         frame_len <= '0;
      end else begin
         // NOTE: strobes default low here; a later non-blocking write in the case wins.
         m_valid <= 1'b0;
         m_sof   <= 1'b0;
         m_eof   <= 1'b0;
         m_err   <= 1'b0;
         if (!eth_rx_dv) rx_armed <= 1'b1;

         case (state)
            IDLE: begin
               if (eth_rx_dv) begin
                  if (rx_armed && eth_rxd == PREAMBLE_NIBBLE) begin
                     state   <= PREAMBLE;
                     pre_cnt <= 4'd1;
                  end else begin
                     state <= DROP;
                  end
               end
            end

            PREAMBLE: begin
               if (!eth_rx_dv) begin
                  state <= IDLE;
               end else if (eth_rxd == PREAMBLE_NIBBLE) begin
                  if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
               end else if (eth_rxd == SFD_NIBBLE && int'(pre_cnt) >= MIN_PREAMBLE) begin
                  state    <= DATA;
                  have_nib <= 1'b0;
                  byte_cnt <= '0;
               end else begin
                  state <= DROP;
               end
            end

            DATA: begin
               if (!eth_rx_dv) begin
                  if (byte_cnt != '0) begin
                     m_data    <= hold_byte;
                     m_valid   <= 1'b1;
                     m_sof     <= (byte_cnt == LEN_W'(1));
                     m_eof     <= 1'b1;
                     m_err     <= have_nib || crc_bad;
                     frame_len <= byte_cnt;
                  end
                  state    <= IDLE;
                  have_nib <= 1'b0;
                  byte_cnt <= '0;
               end else if (!have_nib) begin
                  nib_lo   <= eth_rxd;
                  have_nib <= 1'b1;
               end else begin
                  have_nib <= 1'b0;
                  if (byte_cnt == LEN_W'(MAX_LEN)) begin
                     m_data    <= hold_byte;
                     m_valid   <= 1'b1;
                     m_sof     <= (byte_cnt == LEN_W'(1));
                     m_eof     <= 1'b1;
                     m_err     <= 1'b1;
                     frame_len <= byte_cnt;
                     state     <= DROP;
                     byte_cnt  <= '0;
                  end else begin
                     if (byte_cnt != '0) begin
                        m_data  <= hold_byte;
                        m_valid <= 1'b1;
                        m_sof   <= (byte_cnt == LEN_W'(1));
                     end
                     hold_byte <= {eth_rxd, nib_lo};
                     byte_cnt  <= byte_cnt + LEN_W'(1);
                  end
               end
            end

            DROP: begin
               if (!eth_rx_dv) state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_mii_rx_framer.sv
// Directed bench for eth_mii_rx_framer with a frame-level reference model and a
// per-cycle output comparator. Define ETH_RX_CRC_EN to also exercise FCS checking.
module tb_eth_mii_rx_framer;

   localparam int MIN_PRE = 7;
   localparam int MAX_LEN = 1522;

   typedef logic [7:0] byte_q_t[$];
   typedef struct {
      logic [7:0] data;
      logic       sof;
      logic       eof;
      logic       err;
      int         len;
   } beat_t;

   logic        eth_rx_clk = 1'b0;
   logic        rst        = 1'b1;
   logic        eth_rx_dv  = 1'b0;
   logic [3:0]  eth_rxd    = 4'h0;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_sof;
   logic        m_eof;
   logic        m_err;
   logic [10:0] frame_len;

   int    n_tests = 0;
   int    n_fail  = 0;
   bit    mon_en  = 1'b0;
   beat_t exp_q[$];
   beat_t act_q[$];

   eth_mii_rx_framer #(.MIN_PREAMBLE(MIN_PRE), .MAX_LEN(MAX_LEN)) dut (
      .eth_rx_clk (eth_rx_clk),
      .rst        (rst),
      .eth_rx_dv  (eth_rx_dv),
      .eth_rxd    (eth_rxd),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_sof      (m_sof),
      .m_eof      (m_eof),
      .m_err      (m_err),
      .frame_len  (frame_len)
   );

   always #20 eth_rx_clk = ~eth_rx_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

`ifdef ETH_RX_CRC_EN
   // Byte-wise reflected CRC-32; a frame with a valid FCS leaves 0xDEBB20E3.
   function automatic logic [31:0] crc_reg(input byte_q_t b);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (b[i]) begin
         c = c ^ {24'd0, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction
`endif

   // Expected beats for a frame of 'pre' preamble nibbles, SFD, bytes b, optional dribble nibble.
   function automatic void model_frame(input int pre, input byte_q_t b, input bit odd);
      int n;
      int nb;
      bit err;
      n = b.size();
      if (pre < MIN_PRE || n == 0) return;
      nb  = (n > MAX_LEN) ? MAX_LEN : n;
      err = (n > MAX_LEN) || odd;
`ifdef ETH_RX_CRC_EN
      if (crc_reg(b) != 32'hDEBB_20E3) err = 1'b1;
`endif
      for (int i = 0; i < nb; i++)
         exp_q.push_back('{data: b[i], sof: (i == 0), eof: (i == nb - 1),
                           err: (i == nb - 1) ? err : 1'b0, len: nb});
   endfunction

   function automatic byte_q_t make_bytes(input int n, input int seed);
      byte_q_t b;
      for (int i = 0; i < n; i++) b.push_back(8'((i * 37 + seed) & 255));
      return b;
   endfunction

   always @(negedge eth_rx_clk) begin : compare
      beat_t e;
      if (mon_en) begin
         if (m_valid) begin
            act_q.push_back('{data: m_data, sof: m_sof, eof: m_eof, err: m_err, len: int'(frame_len)});
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("beat", {21'd0, m_data, m_sof, m_eof, m_err}, {21'd0, e.data, e.sof, e.eof, e.err});
               if (e.eof) check("frame_len", 32'(frame_len), 32'(e.len));
            end
         end else begin
            check("idle_flags", {29'd0, m_sof, m_eof, m_err}, 32'd0);
         end
      end
   end

   task automatic drive(input logic dv, input logic [3:0] n);
      @(negedge eth_rx_clk);
      eth_rx_dv = dv;
      eth_rxd   = n;
   endtask

   task automatic send_bytes(input byte_q_t b);
      foreach (b[i]) begin
         drive(1'b1, b[i][3:0]);
         drive(1'b1, b[i][7:4]);
      end
   endtask

   task automatic send_frame(input int pre, input byte_q_t b, input bit odd);
      model_frame(pre, b, odd);
      act_q.delete();
      repeat (pre) drive(1'b1, 4'h5);
      drive(1'b1, 4'hD);
      send_bytes(b);
      if (odd) drive(1'b1, 4'h9);
      repeat (4) drive(1'b0, 4'h0);
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      byte_q_t b;
      byte_q_t abc;
      abc = '{8'hA1, 8'hB2, 8'hC3};

      // Reset state
      repeat (3) drive(1'b0, 4'h0);
      check("reset_outputs", {9'd0, m_data, m_valid, m_sof, m_eof, m_err, frame_len}, 32'd0);
      @(negedge eth_rx_clk);
      rst    = 1'b0;
      mon_en = 1'b1;
      repeat (2) drive(1'b0, 4'h0);

      // Model pinned against hand-computed beats
      model_frame(15, abc, 1'b0);
      check("model_beats", 32'(exp_q.size()), 32'd3);
      check("model_first", {23'd0, exp_q[0].data, exp_q[0].sof}, {23'd0, 8'hA1, 1'b1});
      check("model_last", {22'd0, exp_q[2].data, exp_q[2].sof, exp_q[2].eof}, {22'd0, 8'hC3, 1'b0, 1'b1});
      exp_q.delete();

      // Three-byte frame after a 15-nibble preamble
      send_frame(15, abc, 1'b0);
      check("abc_count", 32'(act_q.size()), 32'd3);
      check("abc_b0", {22'd0, act_q[0].data, act_q[0].sof, act_q[0].eof}, {22'd0, 8'hA1, 1'b1, 1'b0});
      check("abc_b1", {22'd0, act_q[1].data, act_q[1].sof, act_q[1].eof}, {22'd0, 8'hB2, 1'b0, 1'b0});
      check("abc_b2", {22'd0, act_q[2].data, act_q[2].sof, act_q[2].eof}, {22'd0, 8'hC3, 1'b0, 1'b1});
`ifndef ETH_RX_CRC_EN
      check("abc_err", 32'(act_q[2].err), 32'd0);
`endif
      check("abc_len", 32'(frame_len), 32'd3);

      // Short preambles are dropped; frame_len keeps its last value
      send_frame(5, abc, 1'b0);
      check("short5_count", 32'(act_q.size()), 32'd0);
      check("len_held", 32'(frame_len), 32'd3);
      send_frame(6, make_bytes(4, 9), 1'b0);
      check("short6_count", 32'(act_q.size()), 32'd0);
      send_frame(7, make_bytes(4, 9), 1'b0);
      check("min7_count", 32'(act_q.size()), 32'd4);
      send_frame(20, make_bytes(2, 77), 1'b0);
      check("sat20_count", 32'(act_q.size()), 32'd2);

      // Corrupt preamble nibble sends the frame to DROP
      act_q.delete();
      repeat (3) drive(1'b1, 4'h5);
      drive(1'b1, 4'h3);
      repeat (8) drive(1'b1, 4'h5);
      drive(1'b1, 4'hD);
      send_bytes(abc);
      repeat (4) drive(1'b0, 4'h0);
      check("badpre_count", 32'(act_q.size()), 32'd0);

      // One byte plus a dribble nibble
      send_frame(7, '{8'h5A}, 1'b1);
      check("dribble_count", 32'(act_q.size()), 32'd1);
      check("dribble_beat", {21'd0, act_q[0].data, act_q[0].sof, act_q[0].eof, act_q[0].err},
            {21'd0, 8'h5A, 1'b1, 1'b1, 1'b1});
      check("dribble_len", 32'(frame_len), 32'd1);

      // dv falls with no completed byte
      b.delete();
      send_frame(7, b, 1'b0);
      check("empty_count", 32'(act_q.size()), 32'd0);
      send_frame(7, b, 1'b1);
      check("odd_only_count", 32'(act_q.size()), 32'd0);

      // Exactly MAX_LEN bytes
      send_frame(7, make_bytes(MAX_LEN, 21), 1'b0);
      check("maxlen_count", 32'(act_q.size()), 32'(MAX_LEN));
      check("maxlen_eof", 32'(act_q[$].eof), 32'd1);
`ifndef ETH_RX_CRC_EN
      check("maxlen_err", 32'(act_q[$].err), 32'd0);
`endif

      // Oversized frame, then a normal one
      send_frame(7, make_bytes(1600, 3), 1'b0);
      check("ovf_count", 32'(act_q.size()), 32'(MAX_LEN));
      check("ovf_last", {30'd0, act_q[$].eof, act_q[$].err}, {30'd0, 1'b1, 1'b1});
      check("ovf_len", 32'(frame_len), 32'd1522);
      send_frame(7, abc, 1'b0);
      check("post_ovf_count", 32'(act_q.size()), 32'd3);
      check("post_ovf_len", 32'(frame_len), 32'd3);

      // Reset mid-payload with dv held high, preamble-looking data after release
      b = make_bytes(10, 11);
      for (int i = 0; i < 9; i++)
         exp_q.push_back('{data: b[i], sof: (i == 0), eof: 1'b0, err: 1'b0, len: 0});
      act_q.delete();
      repeat (7) drive(1'b1, 4'h5);
      drive(1'b1, 4'hD);
      send_bytes(b);
      @(negedge eth_rx_clk);
      rst     = 1'b1;
      eth_rxd = 4'h3;
      @(negedge eth_rx_clk);
      eth_rxd = 4'h4;
      @(negedge eth_rx_clk);
      rst     = 1'b0;
      eth_rxd = 4'h5;
      repeat (8) drive(1'b1, 4'h5);
      drive(1'b1, 4'hD);
      send_bytes(make_bytes(4, 1));
      repeat (4) drive(1'b0, 4'h0);
      check("rst_drain", 32'(exp_q.size()), 32'd0);
      check("rst_beats", 32'(act_q.size()), 32'd9);
      check("rst_len_cleared", 32'(frame_len), 32'd0);
      send_frame(7, abc, 1'b0);
      check("post_rst_count", 32'(act_q.size()), 32'd3);
      check("post_rst_len", 32'(frame_len), 32'd3);

`ifdef ETH_RX_CRC_EN
      begin
         logic [31:0] fcs;
         b   = make_bytes(60, 5);
         fcs = ~crc_reg(b);
         b.push_back(fcs[7:0]);
         b.push_back(fcs[15:8]);
         b.push_back(fcs[23:16]);
         b.push_back(fcs[31:24]);
         check("model_crc_residue", crc_reg(b), 32'hDEBB_20E3);
         send_frame(7, b, 1'b0);
         check("crc_good_count", 32'(act_q.size()), 32'd64);
         check("crc_good_err", 32'(act_q[$].err), 32'd0);
         b[10] = b[10] ^ 8'h04;
         send_frame(7, b, 1'b0);
         check("crc_bad_count", 32'(act_q.size()), 32'd64);
         check("crc_bad_err", 32'(act_q[$].err), 32'd1);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
